// File: rtl/rv32_mem_pkg.sv
// Shared constants for the RV32 data-memory stage: widths, funct3 size codes,
// access FSM encoding and the alignment rule.
package rv32_mem_pkg;
    localparam int XLEN    = 32;
    localparam int REGADDR = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // funct3[1:0] carries the size; bit 2 only selects zero extension on loads.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            default: return addr_lo == 2'b00;
        endcase
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
interface mem_access_unit_if;
    import rv32_mem_pkg::*;

    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic            dmem_req_we;
    logic [XLEN-1:0] dmem_req_addr;
    logic [XLEN-1:0] dmem_req_wdata;
    logic [3:0]      dmem_req_wstrb;
    logic            dmem_rsp_valid;
    logic [XLEN-1:0] dmem_rsp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a loaded word and sign/zero extends it.
module load_align
    import rv32_mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        sext     = ~funct3[2];
        data     = rdata;
        case (funct3[1:0])
            2'b00:   data = {{24{sext & byte_sel[7]}}, byte_sel};
            2'b01:   data = {{16{sext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues aligned loads/stores on the dmem bus, stalls the
// front of the pipe while an access is outstanding, and holds the MEM/WB register.
module mem_access_unit
    import rv32_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    mem_alu_result,
    input  logic [XLEN-1:0]    mem_store_data,
    input  logic [REGADDR-1:0] mem_rd,
    input  logic               mem_regwrite,
    input  logic               mem_memread,
    input  logic               mem_memwrite,
    input  logic               mem_memtoreg,
    input  logic [2:0]         mem_funct3,
    mem_access_unit_if.master  dmem,
    output logic               mem_stall,
    output logic [XLEN-1:0]    wb_data,
    output logic [REGADDR-1:0] wb_rd,
    output logic               wb_regwrite,
    output logic               wb_misalign
);
    state_e             state_q, state_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic [REGADDR-1:0] wb_rd_q, wb_rd_d;
    logic               wb_regwrite_q, wb_regwrite_d;
    logic               wb_misalign_q, wb_misalign_d;

    logic            mem_op, aligned, access, misalign, in_resp;
    logic [1:0]      offset;
    logic [XLEN-1:0] load_data;

    load_align u_load_align (
        .rdata  (dmem.dmem_rsp_rdata),
        .offset (mem_alu_result[1:0]),
        .funct3 (mem_funct3),
        .data   (load_data)
    );

    always_comb begin
        offset   = mem_alu_result[1:0];
        mem_op   = mem_memread | mem_memwrite;
        aligned  = is_aligned(mem_funct3, offset);
        access   = mem_op & aligned;
        misalign = mem_op & ~aligned;
        in_resp  = (state_q == ST_RESP);

        // Gated by rst so an abandoned access disappears from the bus immediately.
        dmem.dmem_req_valid = access & ~in_resp & ~rst;
        dmem.dmem_req_we    = mem_memwrite;
        dmem.dmem_req_addr  = {mem_alu_result[XLEN-1:2], 2'b00};
        case (mem_funct3[1:0])
            2'b00: begin
                dmem.dmem_req_wdata = {4{mem_store_data[7:0]}};
                dmem.dmem_req_wstrb = 4'b0001 << offset;
            end
            2'b01: begin
                dmem.dmem_req_wdata = {2{mem_store_data[15:0]}};
                dmem.dmem_req_wstrb = 4'b0011 << offset;
            end
            default: begin
                dmem.dmem_req_wdata = mem_store_data;
                dmem.dmem_req_wstrb = 4'b1111;
            end
        endcase

        mem_stall = access
                  & ~(mem_memwrite & dmem.dmem_req_ready & ~in_resp)
                  & ~(in_resp & dmem.dmem_rsp_valid);

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_REQ: begin
                if (dmem.dmem_req_valid) begin
                    if (!dmem.dmem_req_ready) state_d = ST_REQ;
                    else if (mem_memwrite)    state_d = ST_IDLE;
                    else                      state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: if (dmem.dmem_rsp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        wb_data_d     = '0;
        wb_rd_d       = '0;
        wb_regwrite_d = 1'b0;
        wb_misalign_d = 1'b0;
        if (!mem_stall) begin
            if (misalign) begin
                wb_misalign_d = 1'b1;
            end else begin
                wb_data_d     = mem_memtoreg ? load_data : mem_alu_result;
                wb_rd_d       = mem_rd;
                wb_regwrite_d = mem_regwrite;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            wb_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_misalign_q <= wb_misalign_d;
        end
    end

    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_misalign = wb_misalign_q;
endmodule
